// File: rtl/legv8_control_unit.sv
// LEGv8 multi-cycle control unit.
// Three-state FSM (FETCH / EXEC / MEM) that turns the instruction register and
// the ALU zero flag into the full set of datapath control words. Outputs are a
// combinational function of state and IR, and are held at zero while reset is low.
module legv8_control_unit #(
  parameter int DATA_W  = 32'd64,
  parameter int PC_STEP = 32'd4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       IR,
  input  logic [3:0]        status,
  output logic [4:0]        SA,
  output logic [4:0]        SB,
  output logic [4:0]        DA,
  output logic              W,
  output logic [4:0]        FS,
  output logic              C0,
  output logic [DATA_W-1:0] K,
  output logic              B_sel,
  output logic              EN_ALU,
  output logic              EN_B,
  output logic              EN_PC,
  output logic              ENADDRESS_PC,
  output logic              EN_ADDR,
  output logic              OUT_EN,
  output logic              WR_EN,
  output logic [2:0]        PS,
  output logic              IL,
  output logic              instr_done,
  output logic              illegal
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_ADDI = 4'd4,
    OP_SUBI = 4'd5,
    OP_LDUR = 4'd6,
    OP_STUR = 4'd7,
    OP_CBZ  = 4'd8,
    OP_CBNZ = 4'd9,
    OP_B    = 4'd10,
    OP_ILL  = 4'd11
  } op_e;

  state_e             state_r;
  state_e             next_state_s;
  op_e                op_s;
  logic [DATA_W-1:0]  k_imm12_s;
  logic [DATA_W-1:0]  k_dt9_s;
  logic [DATA_W-1:0]  k_cb_s;
  logic [DATA_W-1:0]  k_br_s;
  logic               unused_status_s;

  // Only the Z flag steers branches; the remaining flags are carried for future use.
  assign unused_status_s = ^status[3:1];

  // Immediates. Branch offsets are word offsets; PC_STEP is removed because FETCH
  // has already advanced the PC by one instruction.
  assign k_imm12_s = {{(DATA_W-12){1'b0}}, IR[21:10]};
  assign k_dt9_s   = {{(DATA_W-9){IR[20]}}, IR[20:12]};
  assign k_cb_s    = {{(DATA_W-21){IR[23]}}, IR[23:5], 2'b00} - DATA_W'(PC_STEP);
  assign k_br_s    = {{(DATA_W-28){IR[25]}}, IR[25:0], 2'b00} - DATA_W'(PC_STEP);

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Opcode decode, longest prefix first (11-bit, 10-bit, 8-bit, 6-bit).
  always_comb begin
    op_s = OP_ILL;
    if (IR[31:21] == 11'b10001011000) begin
      op_s = OP_ADD;
    end else if (IR[31:21] == 11'b11001011000) begin
      op_s = OP_SUB;
    end else if (IR[31:21] == 11'b10001010000) begin
      op_s = OP_AND;
    end else if (IR[31:21] == 11'b10101010000) begin
      op_s = OP_ORR;
    end else if (IR[31:21] == 11'b11111000010) begin
      op_s = OP_LDUR;
    end else if (IR[31:21] == 11'b11111000000) begin
      op_s = OP_STUR;
    end else if (IR[31:22] == 10'b1001000100) begin
      op_s = OP_ADDI;
    end else if (IR[31:22] == 10'b1101000100) begin
      op_s = OP_SUBI;
    end else if (IR[31:24] == 8'b10110100) begin
      op_s = OP_CBZ;
    end else if (IR[31:24] == 8'b10110101) begin
      op_s = OP_CBNZ;
    end else if (IR[31:26] == 6'b000101) begin
      op_s = OP_B;
    end else begin
      op_s = OP_ILL;
    end
  end

  // Next-state and control-word generation; everything idles at zero unless driven.
  always_comb begin
    next_state_s = ST_FETCH;
    SA           = 5'd0;
    SB           = 5'd0;
    DA           = 5'd0;
    W            = 1'b0;
    FS           = 5'd0;
    C0           = 1'b0;
    K            = {DATA_W{1'b0}};
    B_sel        = 1'b0;
    EN_ALU       = 1'b0;
    EN_B         = 1'b0;
    EN_PC        = 1'b0;
    ENADDRESS_PC = 1'b0;
    EN_ADDR      = 1'b0;
    OUT_EN       = 1'b0;
    WR_EN        = 1'b0;
    PS           = 3'b000;
    IL           = 1'b0;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    if (!reset) begin
      next_state_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          ENADDRESS_PC = 1'b1;
          OUT_EN       = 1'b1;
          IL           = 1'b1;
          PS           = 3'b001;
          next_state_s = ST_EXEC;
        end
        ST_EXEC: begin
          instr_done   = (op_s != OP_LDUR);
          next_state_s = (op_s == OP_LDUR) ? ST_MEM : ST_FETCH;
          case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
              SA = IR[9:5];
              SB = IR[20:16];
              DA = IR[4:0];
              W  = 1'b1;
              case (op_s)
                OP_ADD:  FS = 5'b01000;
                OP_SUB:  begin FS = 5'b01010; C0 = 1'b1; end
                OP_AND:  FS = 5'b00000;
                OP_ORR:  FS = 5'b00100;
                default: FS = 5'b00000;
              endcase
            end
            OP_ADDI, OP_SUBI: begin
              SA    = IR[9:5];
              DA    = IR[4:0];
              W     = 1'b1;
              B_sel = 1'b1;
              K     = k_imm12_s;
              FS    = (op_s == OP_SUBI) ? 5'b01010 : 5'b01000;
              C0    = (op_s == OP_SUBI);
            end
            OP_LDUR, OP_STUR: begin
              SA      = IR[9:5];
              B_sel   = 1'b1;
              K       = k_dt9_s;
              FS      = 5'b01000;
              EN_ADDR = 1'b1;
              if (op_s == OP_STUR) begin
                SB    = IR[4:0];
                EN_B  = 1'b1;
                WR_EN = 1'b1;
              end else begin
                SB    = 5'd0;
              end
            end
            OP_CBZ, OP_CBNZ: begin
              SA = IR[4:0];
              FS = 5'b11000;
              if (status[0] == (op_s == OP_CBZ)) begin
                PS = 3'b010;
                K  = k_cb_s;
              end else begin
                PS = 3'b000;
              end
            end
            OP_B: begin
              PS = 3'b010;
              K  = k_br_s;
            end
            default: begin
              illegal = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          SA           = IR[9:5];
          B_sel        = 1'b1;
          K            = k_dt9_s;
          FS           = 5'b01000;
          EN_ADDR      = 1'b1;
          OUT_EN       = 1'b1;
          DA           = IR[4:0];
          W            = 1'b1;
          instr_done   = 1'b1;
          next_state_s = ST_FETCH;
        end
        default: begin
          next_state_s = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Testbench for legv8_control_unit: instruction-level reference model checked on
// every cycle, plus directed literal expectations for the key instructions.
module tb_legv8_control_unit;

  localparam int  DATA_W  = 64;
  localparam int  PC_STEP = 4;

  localparam int M_ADD = 0, M_SUB = 1, M_AND = 2, M_ORR = 3, M_LDUR = 4, M_STUR = 5;
  localparam int M_ADDI = 6, M_SUBI = 7, M_CBZ = 8, M_CBNZ = 9, M_B = 10, M_ILL = 11;

  // Opcode table ordered by prefix length, so the first hit is the longest prefix.
  localparam logic [31:0] OP_MASK [11] = '{
    32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
    32'hFFC00000, 32'hFFC00000, 32'hFF000000, 32'hFF000000, 32'hFC000000};
  localparam logic [31:0] OP_VAL [11] = '{
    32'h8B000000, 32'hCB000000, 32'h8A000000, 32'hAA000000, 32'hF8400000, 32'hF8000000,
    32'h91000000, 32'hD1000000, 32'hB4000000, 32'hB5000000, 32'h14000000};

  typedef struct packed {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic        w;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        b_sel;
    logic        en_alu;
    logic        en_b;
    logic        en_pc;
    logic        enaddress_pc;
    logic        en_addr;
    logic        out_en;
    logic        wr_en;
    logic [2:0]  ps;
    logic        il;
    logic        instr_done;
    logic        illegal;
  } ctl_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic [3:0]  status;
  logic [4:0]  SA, SB, DA, FS;
  logic        W, C0, B_sel, EN_ALU, EN_B, EN_PC, ENADDRESS_PC, EN_ADDR, OUT_EN, WR_EN;
  logic [63:0] K;
  logic [2:0]  PS;
  logic        IL, instr_done, illegal;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 0;   // 0 = fetch cycle, 1 = execute cycle, 2 = LDUR memory cycle
  ctl_t act_v;
  ctl_t exp_v;

  legv8_control_unit #(.DATA_W(DATA_W), .PC_STEP(PC_STEP)) dut (
    .clock(clock), .reset(reset), .IR(IR), .status(status),
    .SA(SA), .SB(SB), .DA(DA), .W(W), .FS(FS), .C0(C0), .K(K), .B_sel(B_sel),
    .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_PC(EN_PC), .ENADDRESS_PC(ENADDRESS_PC),
    .EN_ADDR(EN_ADDR), .OUT_EN(OUT_EN), .WR_EN(WR_EN), .PS(PS), .IL(IL),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign act_v = {SA, SB, DA, W, FS, C0, K, B_sel, EN_ALU, EN_B, EN_PC, ENADDRESS_PC,
                  EN_ADDR, OUT_EN, WR_EN, PS, IL, instr_done, illegal};

  function automatic int mnem(input logic [31:0] ir);
    for (int i = 0; i < 11; i++) begin
      if ((ir & OP_MASK[i]) == OP_VAL[i]) return i;
    end
    return M_ILL;
  endfunction

  // Reference: what the control word must be for a given cycle of an instruction.
  function automatic ctl_t model(input int ph, input logic [31:0] ir,
                                 input logic [3:0] st, input logic rst);
    ctl_t   e;
    int     m;
    longint off;
    e = '0;
    m = mnem(ir);
    if (rst && ph == 0) begin
      e.enaddress_pc = 1'b1; e.out_en = 1'b1; e.il = 1'b1; e.ps = 3'b001;
    end else if (rst && ph == 1) begin
      e.instr_done = (m != M_LDUR);
      case (m)
        M_ADD, M_SUB, M_AND, M_ORR: begin
          e.sa = ir[9:5]; e.sb = ir[20:16]; e.da = ir[4:0]; e.w = 1'b1;
          if (m == M_ADD) e.fs = 5'b01000;
          if (m == M_SUB) begin e.fs = 5'b01010; e.c0 = 1'b1; end
          if (m == M_ORR) e.fs = 5'b00100;
        end
        M_ADDI, M_SUBI: begin
          e.sa = ir[9:5]; e.da = ir[4:0]; e.w = 1'b1; e.b_sel = 1'b1;
          e.k = 64'(ir[21:10]);
          e.fs = (m == M_SUBI) ? 5'b01010 : 5'b01000;
          e.c0 = (m == M_SUBI);
        end
        M_LDUR, M_STUR: begin
          off = $signed(ir[20:12]);
          e.sa = ir[9:5]; e.b_sel = 1'b1; e.k = off; e.fs = 5'b01000; e.en_addr = 1'b1;
          if (m == M_STUR) begin e.sb = ir[4:0]; e.en_b = 1'b1; e.wr_en = 1'b1; end
        end
        M_CBZ, M_CBNZ: begin
          e.sa = ir[4:0]; e.fs = 5'b11000;
          if ((m == M_CBZ && st[0]) || (m == M_CBNZ && !st[0])) begin
            off = $signed(ir[23:5]);
            e.ps = 3'b010; e.k = off * 4 - PC_STEP;
          end
        end
        M_B: begin
          off = $signed(ir[25:0]);
          e.ps = 3'b010; e.k = off * 4 - PC_STEP;
        end
        default: e.illegal = 1'b1;
      endcase
    end else if (rst && ph == 2) begin
      off = $signed(ir[20:12]);
      e.sa = ir[9:5]; e.b_sel = 1'b1; e.k = off; e.fs = 5'b01000; e.en_addr = 1'b1;
      e.out_en = 1'b1; e.da = ir[4:0]; e.w = 1'b1; e.instr_done = 1'b1;
    end
    return e;
  endfunction

  // Track which cycle of the current instruction the model is in.
  always @(posedge clock) begin
    if (!reset) phase <= 0;
    else if (phase == 0) phase <= 1;
    else if (phase == 1) phase <= (mnem(IR) == M_LDUR) ? 2 : 0;
    else phase <= 0;
  end

  // Cycle-by-cycle comparison against the model, plus bus/write invariants.
  always @(negedge clock) begin
    exp_v = model(phase, IR, status, reset);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t phase=%0d ir=%h: actual=%h expected=%h",
               $time, phase, IR, act_v, exp_v);
    end
    n_cmp++;
    if ((W && WR_EN) || ($countones({EN_ALU, EN_B, EN_PC, OUT_EN}) > 1)) begin
      n_bad++;
      $display("FAIL invariant t=%0t: W=%b WR_EN=%b bus_en=%b required exclusive",
               $time, W, WR_EN, {EN_ALU, EN_B, EN_PC, OUT_EN});
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic to_next();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  logic [31:0] extra_ir [14] = '{
    32'hCB020023, 32'h8A020023, 32'hAA020023, 32'h913FFCC7, 32'hD1001449,
    32'hF81F8025, 32'hF85F8025, 32'hB5FFFFE4, 32'hB5FFFFE4, 32'hB4000064,
    32'h8B200023, 32'h91400000, 32'h14000010, 32'hFFFFFFFF};
  logic [3:0]  extra_st [14] = '{
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin
    reset  = 1'b0;
    IR     = 32'h0;
    status = 4'h0;
    repeat (3) begin
      to_next();
      sample();
      chk("reset_all_zero", 128'(act_v), 128'd0);
    end

    to_next(); reset = 1'b1; IR = 32'h8B020023;          // FETCH
    sample();
    chk("fetch_IL", IL, 1); chk("fetch_PS", PS, 3'b001);
    chk("fetch_ENADDRESS_PC", ENADDRESS_PC, 1); chk("fetch_OUT_EN", OUT_EN, 1);
    to_next(); sample();                                  // EXEC ADD
    chk("add_SA", SA, 1); chk("add_SB", SB, 2); chk("add_DA", DA, 3); chk("add_W", W, 1);
    chk("add_FS", FS, 5'b01000); chk("add_C0", C0, 0); chk("add_done", instr_done, 1);

    to_next(); IR = 32'hF8408025; sample();               // FETCH
    chk("fetch_after_add_IL", IL, 1);
    to_next(); sample();                                  // EXEC LDUR
    chk("ldur_SA", SA, 1); chk("ldur_K", K, 64'd8); chk("ldur_Bsel", B_sel, 1);
    chk("ldur_EN_ADDR", EN_ADDR, 1); chk("ldur_exec_W", W, 0);
    chk("ldur_exec_done", instr_done, 0);
    to_next(); sample();                                  // MEM
    chk("ldur_mem_OUT_EN", OUT_EN, 1); chk("ldur_mem_DA", DA, 5); chk("ldur_mem_W", W, 1);
    chk("ldur_mem_done", instr_done, 1);

    to_next(); IR = 32'hB4000064; status = 4'b0001; sample();
    to_next(); sample();                                  // CBZ taken
    chk("cbz_taken_PS", PS, 3'b010); chk("cbz_taken_K", K, 64'd8);
    to_next(); status = 4'b0000; sample();
    to_next(); sample();                                  // CBZ not taken
    chk("cbz_not_taken_PS", PS, 3'b000);

    to_next(); IR = 32'h17FFFFFE; sample();
    to_next(); sample();                                  // B -2
    chk("b_PS", PS, 3'b010); chk("b_K", K, 64'hFFFFFFFFFFFFFFF4);

    to_next(); IR = 32'h00000000; sample();
    to_next(); sample();                                  // illegal
    chk("ill_flag", illegal, 1); chk("ill_W", W, 0); chk("ill_WR_EN", WR_EN, 0);
    chk("ill_PS", PS, 3'b000);
    to_next(); sample();
    chk("ill_next_fetch_IL", IL, 1);

    for (int i = 0; i < 14; i++) begin
      IR = extra_ir[i]; status = extra_st[i];
      to_next(); sample();
      if (extra_ir[i][31:21] == 11'b11111000010) begin
        to_next(); sample();
      end
      to_next(); sample();
    end

    IR = 32'hF8408025;                                    // reset during MEM
    to_next(); sample();
    to_next(); reset = 1'b0; sample();
    chk("mem_reset_W", W, 0); chk("mem_reset_OUT_EN", OUT_EN, 0);
    to_next(); reset = 1'b1; sample();
    chk("after_mem_reset_IL", IL, 1); chk("after_mem_reset_W", W, 0);
    to_next(); sample();
    to_next(); sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle control FSM that drives the 64-bit LEGv8 datapath.
- Consumes the instruction register value and the ALU status flags returned by the datapath.
- Produces every datapath control word each cycle: register selects, ALU function, constant, bus enables, memory strobes, PC select and instruction load.
- Sits between the datapath and the top level, replacing bench-driven control words in the integrated processor.

Parameters:
- DATA_W, 64, width of constant K and datapath words.
- PC_STEP, 4, byte increment applied to PC on fetch.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- IR  input  32  instruction register contents from datapath.
- status  input  4  ALU flags {V,C,N,Z}, combinational from the current ALU result.
- SA  output  5  register file A address.
- SB  output  5  register file B address.
- DA  output  5  register file write address.
- W  output  1  register file write enable.
- FS  output  5  ALU function: FS[4:2] op (000 AND, 001 ORR, 010 ADD, 110 pass A); FS[1] invert B; FS[0] invert A.
- C0  output  1  ALU carry-in.
- K  output  DATA_W  constant.
- B_sel  output  1  ALU B input mux: 0 = register B, 1 = K.
- EN_ALU  output  1  ALU drives data bus.
- EN_B  output  1  register B drives data bus.
- EN_PC  output  1  PC drives data bus.
- ENADDRESS_PC  output  1  PC drives memory address.
- EN_ADDR  output  1  ALU result drives memory address.
- OUT_EN  output  1  RAM drives data bus (read).
- WR_EN  output  1  RAM write strobe.
- PS  output  3  PC select: 000 hold, 001 PC+PC_STEP, 010 PC+K, 100 load from bus A.
- IL  output  1  instruction load; IR captures data bus at edge.
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
- illegal  output  1  one-cycle pulse in EXEC for an unrecognised opcode.

Behaviour:
- States: FETCH, EXEC, MEM. Reset state is FETCH. Unused encodings go to FETCH.
- Outputs are a combinational function of state and IR.
- Every output not listed for a state/instruction is 0.
- While reset is low, all outputs are forced to 0.
- Reset low at an edge sets state to FETCH regardless of state, including mid-LDUR in MEM.
- FETCH:
  - ENADDRESS_PC=1, OUT_EN=1, IL=1, PS=001.
  - Next state is EXEC. IR is valid from EXEC onward.
- EXEC decode, using IR[31:21] with longest-prefix match:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
    - SA=IR[9:5], SB=IR[20:16], DA=IR[4:0], W=1.
    - FS: ADD 01000; SUB 01010 with C0=1; AND 00000; ORR 00100.
  - ADDI 1001000100x, SUBI 1101000100x:
    - SA=IR[9:5], DA=IR[4:0], W=1, B_sel=1, K=zero-extend IR[21:10].
    - FS=01000 for ADDI; FS=01010 with C0=1 for SUBI.
  - LDUR 11111000010:
    - SA=IR[9:5], B_sel=1, K=sign-extend IR[20:12], FS=01000, EN_ADDR=1.
    - Next state MEM.
  - MEM (LDUR only):
    - Same address controls as EXEC, plus OUT_EN=1, DA=IR[4:0], W=1.
    - Next state FETCH.
  - STUR 11111000000:
    - Address controls as LDUR, plus SB=IR[4:0], EN_B=1, WR_EN=1.
  - CBZ 10110100, CBNZ 10110101 (IR[31:24]):
    - SA=IR[4:0], FS=11000.
    - Branch taken if status[0]==1 for CBZ, or ==0 for CBNZ.
    - Taken: PS=010, K=(sign-extend IR[23:5] << 2) − PC_STEP. Not taken: PS=000.
  - B 000101 (IR[31:26]):
    - PS=010, K=(sign-extend IR[25:0] << 2) − PC_STEP.
    - The PC_STEP subtraction compensates for the increment already applied in FETCH.
  - Any other opcode: illegal=1, no W/WR_EN/PS activity.
- Next state from EXEC is FETCH, except LDUR which goes to MEM.
- instr_done=1 in EXEC for all non-LDUR instructions and in MEM for LDUR.
- Instruction latency: 2 cycles; LDUR 3 cycles.
- K arithmetic is 64-bit two's complement; overflow wraps.
- Invariants:
  - W and WR_EN are never both 1.
  - At most one of EN_ALU/EN_B/EN_PC/OUT_EN is 1 per cycle.

Test Plan:
- Hold reset low 3 cycles, then release: all outputs 0 during reset; first active cycle is FETCH with IL=1, PS=001, ENADDRESS_PC=1, OUT_EN=1.
- IR=0x8B020023 (ADD X3,X1,X2) in EXEC -> SA=1, SB=2, DA=3, W=1, FS=01000, C0=0, instr_done=1; then FETCH.
- IR=0xF8408025 (LDUR X5,[X1,#8]) -> EXEC: SA=1, K=8, B_sel=1, EN_ADDR=1, W=0; MEM: OUT_EN=1, DA=5, W=1, instr_done=1. Assert reset low during MEM in a second run -> next cycle FETCH, no W.
- IR=0xB4000064 (CBZ X4,+3): status=0001 -> PS=010, K=8; status=0000 -> PS=000.
- IR=0x17FFFFFE (B −2) -> PS=010, K=0xFFFFFFFFFFFFFFF4.
- IR=0x00000000 -> illegal=1, W=0, WR_EN=0, PS=000; next state FETCH.
